// File: rtl/pipelined_controller.sv
// Control and hazard unit for the 5-stage MIPS-subset pipeline: D-stage decode, E/M/W control registers,
// stall/flush/forward generation and D-stage branch/jump redirect; hazard outputs combinational, controls lag D by 1/2/3 cycles.
module pipelined_controller #(
    parameter int RA_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       branch_boolean,
    input  logic [4:0] A1,
    input  logic [4:0] A2,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [5:0] WriteRegE,
    input  logic [5:0] WriteRegM,
    input  logic [5:0] WriteRegW,
    output logic       RegDstE,
    output logic       ALUSrcB,
    output logic [2:0] ALUControlE,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       RegWriteW,
    output logic       PCSrc,
    output logic       JumpC,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [2:0] aluctrl;
        logic       alusrc;
        logic       regdst;
    } ectl_t;

    ectl_t w_dec;
    logic  w_branch_d;
    logic  w_jump_d;

    ectl_t r_ctl_e;
    logic  r_regwrite_m;
    logic  r_memtoreg_m;
    logic  r_memwrite_m;
    logic  r_regwrite_w;
    logic  r_memtoreg_w;

    logic [RA_W-1:0] w_rs_d;
    logic [RA_W-1:0] w_rt_d;
    logic [RA_W-1:0] w_rs_e;
    logic [RA_W-1:0] w_rt_e;
    logic [RA_W-1:0] w_wr_e;
    logic [RA_W-1:0] w_wr_m;
    logic [RA_W-1:0] w_wr_w;

    logic w_lwstall;
    logic w_branchstall;
    logic w_stall;
    logic w_unused_bits;

    // ---------------- D-stage decode ----------------
    always_comb begin
        w_dec      = '0;
        w_branch_d = 1'b0;
        w_jump_d   = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                w_dec.regwrite = 1'b1;
                w_dec.regdst   = 1'b1;
                case (Funct)
                    FN_ADD:  w_dec.aluctrl = ALU_ADD;
                    FN_SUB:  w_dec.aluctrl = ALU_SUB;
                    FN_AND:  w_dec.aluctrl = ALU_AND;
                    FN_OR:   w_dec.aluctrl = ALU_OR;
                    FN_SLT:  w_dec.aluctrl = ALU_SLT;
                    default: w_dec = '0;
                endcase
            end
            OP_LW: begin
                w_dec.regwrite = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.aluctrl  = ALU_ADD;
            end
            OP_SW: begin
                w_dec.memwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.aluctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                w_branch_d    = 1'b1;
                w_dec.aluctrl = ALU_SUB;
            end
            OP_ADDI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.aluctrl  = ALU_ADD;
            end
            OP_J: begin
                w_jump_d = 1'b1;
            end
            default: begin
                w_dec = '0;
            end
        endcase
    end

    // Only the low RA_W bits of each register address take part in comparisons.
    assign w_rs_d = A1[RA_W-1:0];
    assign w_rt_d = A2[RA_W-1:0];
    assign w_rs_e = RsE[RA_W-1:0];
    assign w_rt_e = RtE[RA_W-1:0];
    assign w_wr_e = WriteRegE[RA_W-1:0];
    assign w_wr_m = WriteRegM[RA_W-1:0];
    assign w_wr_w = WriteRegW[RA_W-1:0];

    assign w_unused_bits = ^{A1, A2, RsE, RtE, WriteRegE, WriteRegM, WriteRegW};

    // ---------------- Hazard detection ----------------
    // Stall compares deliberately include register 0 so a load to $0 still stalls.
    assign w_lwstall = r_ctl_e.memtoreg & ((w_rs_d == w_rt_e) | (w_rt_d == w_rt_e));

    assign w_branchstall = w_branch_d &
        ((r_ctl_e.regwrite & ((w_wr_e == w_rs_d) | (w_wr_e == w_rt_d))) |
         (r_memtoreg_m     & ((w_wr_m == w_rs_d) | (w_wr_m == w_rt_d))));

    assign w_stall = w_lwstall | w_branchstall;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;

    // ---------------- Forwarding ----------------
    always_comb begin
        ForwardAE = 2'b00;
        if ((w_rs_e != '0) && r_regwrite_m && (w_rs_e == w_wr_m)) begin
            ForwardAE = 2'b10;
        end else if ((w_rs_e != '0) && r_regwrite_w && (w_rs_e == w_wr_w)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if ((w_rt_e != '0) && r_regwrite_m && (w_rt_e == w_wr_m)) begin
            ForwardBE = 2'b10;
        end else if ((w_rt_e != '0) && r_regwrite_w && (w_rt_e == w_wr_w)) begin
            ForwardBE = 2'b01;
        end
    end

    assign ForwardAD = (w_rs_d != '0) & r_regwrite_m & (w_rs_d == w_wr_m);
    assign ForwardBD = (w_rt_d != '0) & r_regwrite_m & (w_rt_d == w_wr_m);

    // A comparison made while the branch is stalled uses stale operands and must not redirect.
    assign PCSrc = w_branch_d & branch_boolean & ~w_branchstall;
    assign JumpC = w_jump_d;

    // ---------------- Pipeline control registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl_e <= '0;
        end else if (w_stall) begin
            r_ctl_e <= '0;
        end else begin
            r_ctl_e <= w_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_regwrite_m <= r_ctl_e.regwrite;
            r_memtoreg_m <= r_ctl_e.memtoreg;
            r_memwrite_m <= r_ctl_e.memwrite;
            r_regwrite_w <= r_regwrite_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

    assign RegDstE     = r_ctl_e.regdst;
    assign ALUSrcB     = r_ctl_e.alusrc;
    assign ALUControlE = r_ctl_e.aluctrl;
    assign MemWrite    = r_memwrite_m;
    assign MemToReg    = r_memtoreg_w;
    assign RegWriteW   = r_regwrite_w;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: an instruction-level model tracks control words and register
// addresses through E/M/W, drives the datapath-side inputs from it and checks every output each cycle.
module tb_pipelined_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic       branch_boolean;
    logic [4:0] A1, A2, RsE, RtE;
    logic [5:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegDstE, ALUSrcB, MemWrite, MemToReg, RegWriteW;
    logic [2:0] ALUControlE;
    logic       PCSrc, JumpC, StallF, StallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;

    always #5 clk = ~clk;

    pipelined_controller #(.RA_W(5)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .branch_boolean(branch_boolean), .A1(A1), .A2(A2), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegDstE(RegDstE), .ALUSrcB(ALUSrcB), .ALUControlE(ALUControlE),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWriteW(RegWriteW),
        .PCSrc(PCSrc), .JumpC(JumpC), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       bb;
    } instr_t;

    typedef struct packed {
        logic       rw;
        logic       mtr;
        logic       mw;
        logic [2:0] alu;
        logic       asrc;
        logic       rdst;
        logic       br;
        logic       jmp;
    } ctl_t;

    // pipe[0] = E, pipe[1] = M, pipe[2] = W
    ctl_t       pipe [3];
    logic [4:0] e_rs, e_rt, e_wr, m_wr, w_wr;
    logic       m_stall = 1'b0;
    int         checks  = 0;
    int         errors  = 0;

    logic [1:0] l_fae, l_fbe;
    logic [2:0] l_alu;
    logic       l_fad, l_fbd, l_pc, l_jc, l_stf, l_asrc, l_rdst, l_mtr, l_rww;
    logic       pc_in_stall;

    function automatic ctl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (op)
            6'h00: begin
                c.rw   = 1'b1;
                c.rdst = 1'b1;
                case (fn)
                    6'h20:   c.alu = 3'b010;
                    6'h22:   c.alu = 3'b110;
                    6'h24:   c.alu = 3'b000;
                    6'h25:   c.alu = 3'b001;
                    6'h2A:   c.alu = 3'b111;
                    default: c = '0;
                endcase
            end
            6'h23: begin c.rw = 1'b1; c.mtr = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            6'h2B: begin c.mw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            6'h04: begin c.br = 1'b1; c.alu = 3'b110; end
            6'h08: begin c.rw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            6'h02: begin c.jmp = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (src != 5'd0 && pipe[1].rw && src == m_wr) return 2'b10;
        if (src != 5'd0 && pipe[2].rw && src == w_wr) return 2'b01;
        return 2'b00;
    endfunction

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd, input logic bb);
        instr_t x;
        x.op = op; x.fn = fn; x.rs = rs; x.rt = rt; x.rd = rd; x.bb = bb;
        return x;
    endfunction

    function automatic instr_t rnd();
        instr_t x;
        case ($urandom_range(0, 7))
            0, 1:    x.op = 6'h00;
            2:       x.op = 6'h23;
            3:       x.op = 6'h2B;
            4:       x.op = 6'h04;
            5:       x.op = 6'h08;
            6:       x.op = 6'h02;
            default: x.op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       x.fn = 6'h20;
            1:       x.fn = 6'h22;
            2:       x.fn = 6'h24;
            3:       x.fn = 6'h25;
            4:       x.fn = 6'h2A;
            default: x.fn = 6'($urandom);
        endcase
        x.rs = 5'($urandom_range(0, 7));
        x.rt = 5'($urandom_range(0, 7));
        x.rd = 5'($urandom_range(0, 7));
        x.bb = 1'($urandom_range(0, 1));
        return x;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present D instruction and model-derived E/M/W addresses, check, then advance the model.
    task automatic cyc(input instr_t ins, input logic rst, input bit do_chk);
        ctl_t       d;
        logic       lw_st, br_st, stall;
        reset          = rst;
        Opcode         = ins.op;
        Funct          = ins.fn;
        A1             = ins.rs;
        A2             = ins.rt;
        branch_boolean = ins.bb;
        RsE            = e_rs;
        RtE            = e_rt;
        WriteRegE      = {1'($urandom_range(0, 1)), e_wr};
        WriteRegM      = {1'($urandom_range(0, 1)), m_wr};
        WriteRegW      = {1'($urandom_range(0, 1)), w_wr};
        @(negedge clk);
        d     = decode(ins.op, ins.fn);
        lw_st = pipe[0].mtr && (ins.rs == e_rt || ins.rt == e_rt);
        br_st = d.br && ((pipe[0].rw && (e_wr == ins.rs || e_wr == ins.rt)) ||
                         (pipe[1].mtr && (m_wr == ins.rs || m_wr == ins.rt)));
        stall = lw_st || br_st;
        if (do_chk) begin
            chk("RegDstE",     8'(RegDstE),     8'(pipe[0].rdst));
            chk("ALUSrcB",     8'(ALUSrcB),     8'(pipe[0].asrc));
            chk("ALUControlE", 8'(ALUControlE), 8'(pipe[0].alu));
            chk("MemWrite",    8'(MemWrite),    8'(pipe[1].mw));
            chk("MemToReg",    8'(MemToReg),    8'(pipe[2].mtr));
            chk("RegWriteW",   8'(RegWriteW),   8'(pipe[2].rw));
            chk("PCSrc",       8'(PCSrc),       8'(d.br && ins.bb && !br_st));
            chk("JumpC",       8'(JumpC),       8'(d.jmp));
            chk("StallF",      8'(StallF),      8'(stall));
            chk("StallD",      8'(StallD),      8'(stall));
            chk("FlushE",      8'(FlushE),      8'(stall));
            chk("ForwardAE",   8'(ForwardAE),   8'(fwd(e_rs)));
            chk("ForwardBE",   8'(ForwardBE),   8'(fwd(e_rt)));
            chk("ForwardAD",   8'(ForwardAD),   8'(ins.rs != 5'd0 && pipe[1].rw && ins.rs == m_wr));
            chk("ForwardBD",   8'(ForwardBD),   8'(ins.rt != 5'd0 && pipe[1].rw && ins.rt == m_wr));
        end
        l_fae = ForwardAE; l_fbe = ForwardBE; l_fad = ForwardAD; l_fbd = ForwardBD;
        l_pc  = PCSrc;     l_jc  = JumpC;     l_stf = StallF;    l_alu = ALUControlE;
        l_asrc = ALUSrcB;  l_rdst = RegDstE;  l_mtr = MemToReg;  l_rww = RegWriteW;
        m_stall = stall;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            e_rs = '0; e_rt = '0; e_wr = '0; m_wr = '0; w_wr = '0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = stall ? '0 : d;
            w_wr = m_wr;
            m_wr = e_wr;
            if (stall) begin
                e_rs = '0; e_rt = '0; e_wr = '0;
            end else begin
                e_rs = ins.rs;
                e_rt = ins.rt;
                e_wr = (ins.op == 6'h00) ? ins.rd : ins.rt;
            end
        end
    endtask

    // Present an instruction in D until it leaves; reports how many stall cycles it saw.
    task automatic run(input instr_t ins, output int stalls);
        bit done;
        done        = 1'b0;
        stalls      = 0;
        pc_in_stall = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            cyc(ins, 1'b0, 1'b1);
            if (m_stall) begin
                stalls++;
                pc_in_stall = pc_in_stall | l_pc;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_bound stall persisted observed=%0d cycles expected<8", stalls);
        end
    endtask

    task automatic drain();
        int s;
        for (int k = 0; k < 3; k++) run('0, s);
    endtask

    initial begin
        int     s;
        instr_t cur;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        e_rs = '0; e_rt = '0; e_wr = '0; m_wr = '0; w_wr = '0;
        reset = 1'b1; Opcode = '0; Funct = '0; branch_boolean = 1'b0;
        A1 = '0; A2 = '0; RsE = '0; RtE = '0; WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a load in D, then the load flows through.
        cyc(mk(6'h23, 6'h00, 5'd0, 5'd1, 5'd0, 1'b0), 1'b1, 1'b0);
        cyc(mk(6'h23, 6'h00, 5'd0, 5'd1, 5'd0, 1'b0), 1'b1, 1'b1);
        chk("rst_alusrc", 8'(l_asrc), 8'd0);
        chk("rst_rww",    8'(l_rww),  8'd0);
        chk("rst_stall",  8'(l_stf),  8'd0);
        run(mk(6'h23, 6'h00, 5'd0, 5'd1, 5'd0, 1'b0), s);
        run('0, s);
        chk("lw_e_alusrc", 8'(l_asrc), 8'd1);
        chk("lw_e_alu",    8'(l_alu),  8'b010);
        run('0, s);
        run('0, s);
        chk("lw_w_memtoreg", 8'(l_mtr), 8'd1);
        chk("lw_w_regwrite", 8'(l_rww), 8'd1);

        // ALU-to-ALU forwarding from M, from W, and never from $0.
        drain();
        run(mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0), s);
        run(mk(6'h00, 6'h22, 5'd3, 5'd1, 5'd4, 1'b0), s);
        run('0, s);
        chk("fwd_from_m", 8'(l_fae), 8'b10);
        drain();
        run(mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0), s);
        run('0, s);
        run(mk(6'h00, 6'h22, 5'd3, 5'd1, 5'd4, 1'b0), s);
        run('0, s);
        chk("fwd_from_w", 8'(l_fae), 8'b01);
        drain();
        run(mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0), s);
        run(mk(6'h00, 6'h22, 5'd0, 5'd1, 5'd4, 1'b0), s);
        run('0, s);
        chk("fwd_reg0", 8'(l_fae), 8'b00);

        // Load-use: one bubble, then both operands from W.
        drain();
        run(mk(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0), s);
        run(mk(6'h00, 6'h20, 5'd5, 5'd5, 5'd6, 1'b0), s);
        chk("lwuse_stalls", 8'(s), 8'd1);
        chk("bubble_alu",   8'(l_alu),  8'd0);
        chk("bubble_rdst",  8'(l_rdst), 8'd0);
        run('0, s);
        chk("lwuse_fae", 8'(l_fae), 8'b01);
        chk("lwuse_fbe", 8'(l_fbe), 8'b01);

        // Branch after ALU producer: one stall, then taken with D-stage forwarding.
        drain();
        run(mk(6'h08, 6'h00, 5'd0, 5'd7, 5'd0, 1'b0), s);
        run(mk(6'h04, 6'h00, 5'd7, 5'd7, 5'd0, 1'b1), s);
        chk("br_alu_stalls", 8'(s), 8'd1);
        chk("br_alu_pc_stall", 8'(pc_in_stall), 8'd0);
        chk("br_alu_pcsrc", 8'(l_pc),  8'd1);
        chk("br_alu_fad",   8'(l_fad), 8'd1);
        chk("br_alu_fbd",   8'(l_fbd), 8'd1);

        // Branch after load: two stalls, no redirect while stalled.
        drain();
        run(mk(6'h23, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0), s);
        run(mk(6'h04, 6'h00, 5'd8, 5'd0, 5'd0, 1'b1), s);
        chk("br_lw_stalls",   8'(s), 8'd2);
        chk("br_lw_pc_stall", 8'(pc_in_stall), 8'd0);

        // Jump resolves in D without stalling; unknown opcode is a NOP end to end.
        drain();
        run(mk(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0), s);
        chk("jump_c",     8'(l_jc),  8'd1);
        chk("jump_stall", 8'(l_stf), 8'd0);
        run(mk(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0), s);
        run('0, s);
        chk("unk_alusrc", 8'(l_asrc), 8'd0);
        chk("unk_rdst",   8'(l_rdst), 8'd0);
        run('0, s);
        run('0, s);
        chk("unk_rww", 8'(l_rww), 8'd0);

        // Random instruction stream; a stalled instruction stays in D, occasional resets.
        cur = rnd();
        for (int i = 0; i < 800; i++) begin
            logic r;
            if (!m_stall) cur = rnd();
            r = ($urandom_range(0, 59) == 0);
            cyc(cur, r, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
